// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and FSM state encoding for the UART transmit FIFO.
package uart_tx_fifo_pkg;

   localparam int unsigned UART_BYTE_W  = 8;
   localparam int unsigned BUSY_TIMEOUT = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Simple dual-port byte RAM for the transmit FIFO: sync write, registered sync read.
module uart_tx_fifo_mem #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_12mhz,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_12mhz) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register only loads on a launch, so it holds the byte in flight.
   always_ff @(posedge clk_12mhz) begin
      if (!reset_n)   rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding async_transmitter.
// Optional drop counter port enabled by UART_TX_FIFO_DROP_CNT_EN.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DATA_WIDTH = UART_BYTE_W
) (
   input  logic                  clk_12mhz,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  txd_busy,
   output logic                  txd_start,
   output logic [DATA_WIDTH-1:0] txd_data,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow
`ifdef UART_TX_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]           drop_count
`endif
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned TW    = $clog2(BUSY_TIMEOUT) + 1;

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic [TW-1:0]         wait_cnt;
   tx_state_t             state;
   logic                  pop;
   logic                  wr_en;
   logic                  wr_drop;
   logic                  rd_en;

   // A full FIFO still accepts a write in the same cycle as the launch pop.
   assign pop        = (state == ST_LAUNCH);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));
   assign fifo_count = count;
   assign wr_en      = wr_valid && (!fifo_full || pop);
   assign wr_drop    = wr_valid && fifo_full && !pop;
   assign rd_en      = (state == ST_IDLE) && !fifo_empty && !txd_busy;

   uart_tx_fifo_mem #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_WIDTH)
   ) u_mem (
      .clk_12mhz (clk_12mhz),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_ptr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_ptr),
      .rd_data   (txd_data)
   );

   always_ff @(posedge clk_12mhz) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)   wr_ptr   <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)     rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
         if (wr_drop) overflow <= 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Launch sequencer; WAIT_BUSY times out in case the transmitter missed the start.
   always_ff @(posedge clk_12mhz) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         txd_start <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         txd_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_en) begin
                  state     <= ST_LAUNCH;
                  txd_start <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               state    <= ST_WAIT_BUSY;
               wait_cnt <= '0;
            end
            ST_WAIT_BUSY: begin
               if (txd_busy)                                 state    <= ST_WAIT_DONE;
               else if (wait_cnt == TW'(BUSY_TIMEOUT - 1))   state    <= ST_IDLE;
               else                                          wait_cnt <= wait_cnt + TW'(1);
            end
            ST_WAIT_DONE: begin
               if (!txd_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef UART_TX_FIFO_DROP_CNT_EN
   // Saturating count of dropped writes.
   always_ff @(posedge clk_12mhz) begin
      if (!reset_n)
         drop_count <= '0;
      else if (wr_drop && (drop_count != 16'hFFFF))
         drop_count <= drop_count + 16'd1;
   end
`endif

endmodule
